// File: rtl/arm_mem_defs.sv
// Shared definitions for the SRAM memory controller: widths, default base
// address, FSM state encoding and half-word helpers.
package arm_mem_defs;

   localparam int CPU_W   = 32;
   localparam int SRAM_AW = 17;
   localparam int SRAM_DW = 64;

   localparam logic [CPU_W-1:0] BASE_ADDR_DEF = 32'd1024;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Replace one 32-bit half of a 64-bit SRAM line; sel=1 selects the upper half.
   function automatic logic [SRAM_DW-1:0] merge_half(input logic [SRAM_DW-1:0] line,
                                                     input logic               sel,
                                                     input logic [CPU_W-1:0]   wd);
      merge_half = sel ? {wd, line[CPU_W-1:0]} : {line[SRAM_DW-1:CPU_W], wd};
   endfunction

   // Extract one 32-bit half of a 64-bit SRAM line.
   function automatic logic [CPU_W-1:0] pick_half(input logic [SRAM_DW-1:0] line,
                                                  input logic               sel);
      pick_half = sel ? line[SRAM_DW-1:CPU_W] : line[CPU_W-1:0];
   endfunction

endpackage

// File: rtl/sram_line_buf.sv
// Single-entry line buffer: valid bit, 17-bit tag and one 64-bit SRAM line.
// Only instantiated by sram_mem_ctrl when SRAM_LINE_BUF_EN is defined.
module sram_line_buf
   import arm_mem_defs::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SRAM_AW-1:0] lookup_tag_i,
   input  logic               upd_i,
   input  logic [SRAM_AW-1:0] upd_tag_i,
   input  logic [SRAM_DW-1:0] upd_line_i,
   output logic               hit_o,
   output logic [SRAM_DW-1:0] line_o
);

   logic               valid_q;
   logic [SRAM_AW-1:0] tag_q;
   logic [SRAM_DW-1:0] data_q;

   // Capture the final line of every completed access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (upd_i) begin
         valid_q <= 1'b1;
         tag_q   <= upd_tag_i;
         data_q  <= upd_line_i;
      end
   end

   assign hit_o  = valid_q && (tag_q == lookup_tag_i);
   assign line_o = data_q;

endmodule

// File: rtl/sram_mem_ctrl.sv
// CPU-to-SRAM controller: turns 32-bit word reads/writes into multi-cycle
// accesses on a 64-bit SRAM, with read-modify-write for 32-bit writes.
// Optional feature macro: SRAM_LINE_BUF_EN adds a single-entry line buffer.
//
// state  | meaning
// IDLE   | waiting for a request; latches address/half/wdata on exit
// RD     | SRAM read phase for a CPU read, SRAM_WAIT cycles
// RMW_RD | SRAM read phase of a write, fetches the full line
// RMW_WR | SRAM write phase, drives merged line with WE_N low
// DONE   | one cycle, ready=1, rdata valid
module sram_mem_ctrl
   import arm_mem_defs::*;
#(
   parameter logic [CPU_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int               SRAM_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [CPU_W-1:0]   address,
   input  logic [CPU_W-1:0]   wdata,
   output logic [CPU_W-1:0]   rdata,
   output logic               ready,
   output logic               SRAM_WE_N,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

   localparam int               CNT_W    = $clog2(SRAM_WAIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_WAIT - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic               sel_q, sel_d;
   logic [CPU_W-1:0]   wdata_q, wdata_d;
   logic [SRAM_DW-1:0] line_q, line_d;
   logic [CPU_W-1:0]   rdata_q, rdata_d;

   logic [CPU_W-1:0]   off;
   logic [SRAM_AW-1:0] req_tag;
   logic               req_sel;
   logic [SRAM_DW-1:0] merged;
   logic               buf_hit;
   logic [SRAM_DW-1:0] buf_line;
   logic               buf_upd;
   logic               rd_hit;
   logic               unused_off_bits;

   // Bits above the 17-bit word index and the byte offset are don't-care.
   assign off             = address - BASE_ADDR;
   assign req_tag         = off[19:3];
   assign req_sel         = off[2];
   assign unused_off_bits = ^{off[CPU_W-1:20], off[1:0]};

   assign merged = merge_half(line_q, sel_q, wdata_q);

`ifdef SRAM_LINE_BUF_EN
   sram_line_buf u_line_buf (
      .clk          (clk),
      .rst_n        (rst),
      .lookup_tag_i (req_tag),
      .upd_i        (buf_upd),
      .upd_tag_i    (addr_q),
      .upd_line_i   (line_d),
      .hit_o        (buf_hit),
      .line_o       (buf_line)
   );
`else
   logic unused_buf_upd;
   assign buf_hit        = 1'b0;
   assign buf_line       = '0;
   assign unused_buf_upd = buf_upd;
`endif

   // A read that hits the buffer completes in IDLE without touching the SRAM.
   assign rd_hit = (state_q == IDLE) && rd_en && !wr_en && buf_hit;

   assign ready     = !(rd_en || wr_en) || (state_q == DONE) || rd_hit;
   assign rdata     = rd_hit ? pick_half(buf_line, req_sel) : rdata_q;
   assign SRAM_WE_N = (state_q != RMW_WR);
   assign SRAM_ADDR = addr_q;
   assign SRAM_DQ   = (state_q == RMW_WR) ? merged : {SRAM_DW{1'bz}};

   // State and datapath registers; reset returns the SRAM bus to idle at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         sel_q   <= 1'b0;
         wdata_q <= '0;
         line_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         line_q  <= line_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and datapath updates; a dropped request never aborts a phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      line_d  = line_q;
      rdata_d = rdata_q;
      buf_upd = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_en) begin
               addr_d  = req_tag;
               sel_d   = req_sel;
               wdata_d = wdata;
               cnt_d   = CNT_LOAD;
               if (buf_hit) begin
                  line_d  = buf_line;
                  state_d = RMW_WR;
               end else begin
                  state_d = RMW_RD;
               end
            end else if (rd_en && !buf_hit) begin
               addr_d  = req_tag;
               sel_d   = req_sel;
               wdata_d = wdata;
               cnt_d   = CNT_LOAD;
               state_d = RD;
            end
         end
         RD, RMW_RD: begin
            if (cnt_q == '0) begin
               line_d = SRAM_DQ;
               if (state_q == RD) begin
                  rdata_d = pick_half(SRAM_DQ, sel_q);
                  buf_upd = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = RMW_WR;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RMW_WR: begin
            if (cnt_q == '0) begin
               line_d  = merged;
               rdata_d = wdata_q;
               buf_upd = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a behavioural 64-bit SRAM model.
module tb_sram_mem_ctrl;

`ifdef SRAM_LINE_BUF_EN
   localparam int WR_HIT_STALL = 5;
   localparam int RD_HIT_STALL = 0;
`else
   localparam int WR_HIT_STALL = 9;
   localparam int RD_HIT_STALL = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        SRAM_WE_N;
   logic [16:0] SRAM_ADDR;
   wire  [63:0] SRAM_DQ;

   logic [63:0] mem [0:131071];
   logic        sram_oe = 1'b1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sram_mem_ctrl #(.BASE_ADDR(32'd1024), .SRAM_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ)
   );

   assign SRAM_DQ = (SRAM_WE_N && sram_oe) ? mem[SRAM_ADDR] : {64{1'bz}};

   always @(posedge clk) begin
      if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request at posedge+1 and hold it until ready; returns stall length.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, output int stall, output int we_low,
                         output logic [31:0] rd_val, output logic [16:0] sa);
      address = a;
      wdata   = wd;
      rd_en   = rd;
      wr_en   = wr;
      stall   = 0;
      we_low  = 0;
      rd_val  = '0;
      sa      = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!SRAM_WE_N) we_low++;
         if (ready) begin
            rd_val = rdata;
            break;
         end
         stall++;
         sa = SRAM_ADDR;
      end
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      int          stall;
      int          we_low;
      logic [31:0] rv;
      logic [16:0] sa;
      logic        seen;

      mem[0]         = 64'hAAAA_AAAA_5555_5555;
      mem[2]         = 64'h0123_4567_89AB_CDEF;
      mem[3]         = 64'hFFFF_0000_FFFF_0000;
      mem[5]         = 64'h1111_2222_3333_4444;
      mem[17'h1FFFF] = 64'hCAFE_F00D_0BAD_BEEF;

      #1;
      chk("rst_rdata", 64'(rdata), 64'h0);
      chk("rst_we_n", 64'(SRAM_WE_N), 64'h1);
      chk("rst_addr", 64'(SRAM_ADDR), 64'h0);
      chk("rst_ready", 64'(ready), 64'h1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic write with read-modify-write
      do_req(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, stall, we_low, rv, sa);
      chk("wr_stall", 64'(stall), 64'd9);
      chk("wr_we_low", 64'(we_low), 64'd4);
      chk("wr_mem0", mem[0], 64'hAAAA_AAAA_DEAD_BEEF);

      // Read-back of both halves
      do_req(1'b0, 1'b1, 32'd1028, 32'h1234_5678, stall, we_low, rv, sa);
      chk("wr2_stall", 64'(stall), 64'(WR_HIT_STALL));
      chk("wr2_mem0", mem[0], 64'h1234_5678_DEAD_BEEF);
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, stall, we_low, rv, sa);
      chk("rb_lo_data", 64'(rv), 64'hDEAD_BEEF);
      chk("rb_lo_stall", 64'(stall), 64'(RD_HIT_STALL));
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, stall, we_low, rv, sa);
      chk("rb_hi_data", 64'(rv), 64'h1234_5678);
      chk("rb_hi_stall", 64'(stall), 64'(RD_HIT_STALL));
      chk("rb_we_low", 64'(we_low), 64'd0);

      // Address mapping and wrap
      do_req(1'b1, 1'b0, 32'd1068, 32'h0, stall, we_low, rv, sa);
      chk("map5_addr", 64'(sa), 64'd5);
      chk("map5_data", 64'(rv), 64'h1111_2222);
      chk("map5_stall", 64'(stall), 64'd5);
      do_req(1'b1, 1'b0, 32'd1020, 32'h0, stall, we_low, rv, sa);
      chk("wrap_addr", 64'(sa), 64'h1FFFF);
      chk("wrap_data", 64'(rv), 64'hCAFE_F00D);

      // Priority (write wins) and flush in the 2nd RMW_WR cycle
      address = 32'd1040;
      wdata   = 32'h55AA_55AA;
      rd_en   = 1'b1;
      wr_en   = 1'b1;
      we_low  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!SRAM_WE_N) begin
            we_low++;
            if (we_low == 2) begin
               rd_en = 1'b0;
               wr_en = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("flush_we_low", 64'(we_low), 64'd4);
      chk("flush_mem2", mem[2], 64'h0123_4567_55AA_55AA);
      do_req(1'b1, 1'b0, 32'd1044, 32'h0, stall, we_low, rv, sa);
      chk("flush_rd_data", 64'(rv), 64'h0123_4567);
      chk("flush_rd_stall", 64'(stall), 64'(RD_HIT_STALL));

      // Asynchronous reset during RMW_WR
      address = 32'd1048;
      wdata   = 32'h1357_9BDF;
      wr_en   = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!SRAM_WE_N) begin
            seen = 1'b1;
            break;
         end
      end
      chk("mid_wr_reached", 64'(seen), 64'h1);
      sram_oe = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_we_n", 64'(SRAM_WE_N), 64'h1);
      chk("async_rdata", 64'(rdata), 64'h0);
      chk("async_addr", 64'(SRAM_ADDR), 64'h0);
      chk("async_dq_released", 64'(SRAM_DQ !== 64'hFFFF_0000_1357_9BDF), 64'h1);
      wr_en = 1'b0;
      @(negedge clk);
      rst     = 1'b1;
      sram_oe = 1'b1;
      @(posedge clk);
      #1;
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, stall, we_low, rv, sa);
      chk("post_rst_data", 64'(rv), 64'hDEAD_BEEF);
      chk("post_rst_stall", 64'(stall), 64'd5);

      // Line-buffer sequence (miss, neighbour read, write to same line)
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, stall, we_low, rv, sa);
      chk("lb_miss_stall", 64'(stall), 64'd5);
      chk("lb_miss_data", 64'(rv), 64'hDEAD_BEEF);
      do_req(1'b1, 1'b0, 32'd1028, 32'h0, stall, we_low, rv, sa);
      chk("lb_hit_stall", 64'(stall), 64'(RD_HIT_STALL));
      chk("lb_hit_data", 64'(rv), 64'h1234_5678);
      do_req(1'b0, 1'b1, 32'd1024, 32'hA5A5_A5A5, stall, we_low, rv, sa);
      chk("lb_wr_stall", 64'(stall), 64'(WR_HIT_STALL));
      chk("lb_wr_we_low", 64'(we_low), 64'd4);
      chk("lb_wr_mem0", mem[0], 64'h1234_5678_A5A5_A5A5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
